// File: rtl/cmd_mem_bridge.sv
// -----------------------------------------------------------------------------
// cmd_mem_bridge
// Host-facing byte-stream command engine. Fixed-size little-endian headers are
// collected from the input stream, then dispatched against a local byte RAM
// and a small register file (CTRL, STATUS, CMD_CNT).
//
// Header layout (bit 0 = bit 0 of the first byte):
//   [3:0]                    ID    command
//   [ADDR_W+3:4]             ADDR  start address / register select
//   [ADDR_W+LEN_W+3:ADDR_W+4] LEN  transfer moves LEN+1 bytes
// IDs: 0 RESET, 1 READ, 2 WRITE, 3 REGRD, 4 REGWR, 5..15 error (sticky ERR).
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_in_valid/i_in_data/o_in_ready     input byte stream (valid/ready)
//   o_out_valid/o_out_data/i_out_ready  output byte stream (valid/ready)
//   o_dev_rst                   device reset pulse, RST_CYCLES long
//   o_dev_en                    device enable, CTRL[0]
//   i_dev_addr/o_dev_rdata      device-side RAM read port, 1-cycle latency
//   o_busy                      high whenever a command is in progress
//
// Build option: define CMD_MEM_BRIDGE_ACK_EN to emit an acknowledge byte
// {4'hA, ID} after RESET, WRITE and REGWR, and 0xEE for an unknown ID.
// -----------------------------------------------------------------------------
module cmd_mem_bridge #(
  parameter int ADDR_W     = 14,
  parameter int LEN_W      = 14,
  parameter int RST_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [7:0]        o_out_data,
  input  logic              i_out_ready,
  output logic              o_dev_rst,
  output logic              o_dev_en,
  input  logic [ADDR_W-1:0] i_dev_addr,
  output logic [7:0]        o_dev_rdata,
  output logic              o_busy
);

  localparam int HDR_BYTES = (4 + ADDR_W + LEN_W + 7) / 8;
  localparam int HDR_BITS  = HDR_BYTES * 8;
  localparam int BCNT_W    = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int CNT_W     = LEN_W + 1;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR,
    S_EXEC,
    S_RST,
    S_READ,
    S_WRITE,
    S_EMIT     // one output byte (REGRD result or ack) awaiting handshake
  } state_t;

  state_t              state_q, state_d;
  logic [HDR_BITS-1:0] hdr_q, hdr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // bytes left, or reset cycles left
  logic [7:0]          ctrl_q, ctrl_d;
  logic                err_q, err_d;
  logic [7:0]          cmd_cnt_q, cmd_cnt_d;

  logic                out_valid_q;
  logic [7:0]          out_data_q;
  logic [7:0]          dev_rdata_q;

  logic                in_ready;
  logic                mem_we;
  logic                out_load;
  logic                out_sel_mem;
  logic [7:0]          out_byte;

  logic [7:0]          ram [0:DEPTH-1];

  logic [3:0]          hdr_id;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic [7:0]          status;
  logic                out_free;

  assign hdr_id   = hdr_q[3:0];
  assign hdr_addr = hdr_q[ADDR_W+3:4];
  assign hdr_len  = hdr_q[ADDR_W+LEN_W+3:ADDR_W+4];
  assign status   = {6'b0, err_q, ctrl_q[0]};
  // The output register can take a new byte when empty or being drained now.
  assign out_free = !out_valid_q || i_out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    bcnt_d      = bcnt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    err_d       = err_q;
    cmd_cnt_d   = cmd_cnt_q;
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    out_load    = 1'b0;
    out_sel_mem = 1'b0;
    out_byte    = 8'h00;

    case (state_q)
      S_HDR: begin
        in_ready = 1'b1;
        if (i_in_valid) begin
          hdr_d[{bcnt_q, 3'b000} +: 8] = i_in_data;
          if (bcnt_q == BCNT_W'(HDR_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = S_EXEC;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end

      S_EXEC: begin
        cmd_cnt_d = cmd_cnt_q + 8'd1;
        addr_d    = hdr_addr;
        cnt_d     = {1'b0, hdr_len} + CNT_W'(1);
        state_d   = S_HDR;
        case (hdr_id)
          4'd0: begin
            cnt_d   = CNT_W'(RST_CYCLES - 1);
            state_d = S_RST;
          end
          4'd1: state_d = S_READ;
          4'd2: state_d = S_WRITE;
          4'd3: begin
            // Reports the count before this command is included.
            out_load = 1'b1;
            case (hdr_addr[1:0])
              2'd0:    out_byte = ctrl_q;
              2'd1:    out_byte = status;
              2'd2:    out_byte = cmd_cnt_q;
              default: out_byte = 8'h00;
            endcase
            state_d = S_EMIT;
          end
          4'd4: begin
            if (hdr_addr[1:0] == 2'd0) begin
              ctrl_d = hdr_len[7:0];
            end else if (hdr_addr[1:0] == 2'd1 && hdr_len[1]) begin
              err_d = 1'b0;
            end
`ifdef CMD_MEM_BRIDGE_ACK_EN
            out_load = 1'b1;
            out_byte = {4'hA, hdr_id};
            state_d  = S_EMIT;
`endif
          end
          default: begin
            err_d = 1'b1;
`ifdef CMD_MEM_BRIDGE_ACK_EN
            out_load = 1'b1;
            out_byte = 8'hEE;
            state_d  = S_EMIT;
`endif
          end
        endcase
      end

      S_RST: begin
        if (cnt_q == '0) begin
`ifdef CMD_MEM_BRIDGE_ACK_EN
          out_load = 1'b1;
          out_byte = {4'hA, hdr_id};
          state_d  = S_EMIT;
`else
          state_d = S_HDR;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_READ: begin
        if (cnt_q != '0) begin
          if (out_free) begin
            out_load    = 1'b1;
            out_sel_mem = 1'b1;
            addr_d      = addr_q + ADDR_W'(1);
            cnt_d       = cnt_q - CNT_W'(1);
          end
        end else if (out_free) begin
          // Last byte fetched; leave once it has been handed over.
          state_d = S_HDR;
        end
      end

      S_WRITE: begin
        in_ready = 1'b1;
        if (i_in_valid) begin
          mem_we = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef CMD_MEM_BRIDGE_ACK_EN
            out_load = 1'b1;
            out_byte = {4'hA, hdr_id};
            state_d  = S_EMIT;
`else
            state_d = S_HDR;
`endif
          end
        end
      end

      S_EMIT: begin
        if (out_valid_q && i_out_ready) begin
          state_d = S_HDR;
        end
      end

      default: state_d = S_HDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_HDR;
      hdr_q     <= '0;
      bcnt_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ctrl_q    <= 8'h00;
      err_q     <= 1'b0;
      cmd_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      bcnt_q    <= bcnt_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      err_q     <= err_d;
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM: host port (write, or registered read into the output register) and
  // device read port. Contents are not affected by reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (mem_we && i_rst_n) begin
      ram[addr_q] <= i_in_data;
    end
  end

  // Output register doubles as the host-port read register; held on stall.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_sel_mem ? ram[addr_q] : out_byte;
    end else if (i_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Read-before-write: a same-cycle host write returns the old byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dev_rdata_q <= 8'h00;
    end else begin
      dev_rdata_q <= ram[i_dev_addr];
    end
  end

  assign o_in_ready  = in_ready && i_rst_n;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_dev_rst   = (state_q == S_RST);
  assign o_dev_en    = ctrl_q[0];
  assign o_dev_rdata = dev_rdata_q;
  assign o_busy      = (state_q != S_HDR);

endmodule

// File: tb/tb_cmd_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_cmd_mem_bridge
// Directed bench for cmd_mem_bridge (default parameters). Inputs are driven on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cmd_mem_bridge;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [7:0]  o_out_data;
  logic        i_out_ready;
  logic        o_dev_rst;
  logic        o_dev_en;
  logic [13:0] i_dev_addr;
  logic [7:0]  o_dev_rdata;
  logic        o_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  cmd_mem_bridge dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .i_out_ready (i_out_ready),
    .o_dev_rst   (o_dev_rst),
    .o_dev_en    (o_dev_en),
    .i_dev_addr  (i_dev_addr),
    .o_dev_rdata (o_dev_rdata),
    .o_busy      (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    i_in_valid = 1'b1;
    i_in_data  = b;
    while (!o_in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [3:0] id, input logic [13:0] addr, input logic [13:0] len);
    logic [31:0] h;
    h = {len, addr, id};
    $display("[tb] cmd id=%0d addr=0x%04h len=%0d", id, addr, len);
    for (int i = 0; i < 4; i++) send_byte(h[i*8 +: 8]);
  endtask

  // Collect n output bytes into rx_q; optionally toggle ready 1/0 and verify
  // that a stalled byte is held unchanged.
  task automatic collect(input int n, input bit toggle);
    int cyc = 0;
    int got = 0;
    logic [7:0] held = 8'h00;
    bit hv = 1'b0;
    rx_q.delete();
    while (got < n && cyc < 500) begin
      i_out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (hv) check("stall_hold", {24'h0, o_out_data}, {24'h0, held});
      hv = 1'b0;
      if (o_out_valid && i_out_ready) begin
        rx_q.push_back(o_out_data);
        got++;
      end else if (o_out_valid) begin
        held = o_out_data;
        hv   = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    i_out_ready = 1'b0;
    if (got < n) check("rx_timeout", got, n);
  endtask

  task automatic wait_idle;
    int guard = 0;
    while (o_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_ack(input logic [7:0] exp);
`ifdef CMD_MEM_BRIDGE_ACK_EN
    collect(1, 1'b0);
    check("ack", rx_at(0), {24'h0, exp});
`else
    if (exp == 8'h00) begin end
`endif
  endtask

  task automatic regrd(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    send_hdr(4'd3, {12'h0, sel}, 14'd0);
    collect(1, 1'b0);
    check(tag, rx_at(0), {24'h0, exp});
    wait_idle();
  endtask

  task automatic dev_check(input logic [13:0] a, input logic [7:0] exp, input string tag);
    i_dev_addr = a;
    @(negedge clk);
    check(tag, {24'h0, o_dev_rdata}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] exp1 [4];
    int cnt;
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44};

    i_rst_n     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = 8'h00;
    i_out_ready = 1'b0;
    i_dev_addr  = 14'h0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_data",  o_out_data, 0);
    check("rst_dev_rst",   o_dev_rst, 0);
    check("rst_dev_en",    o_dev_en, 0);
    check("rst_busy",      o_busy, 0);
    check("rst_dev_rdata", o_dev_rdata, 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", o_in_ready, 1);

    // 1: write 4 bytes at 0x10, read them back
    send_hdr(4'd2, 14'h0010, 14'd3);
    foreach (exp1[i]) send_byte(exp1[i]);
    expect_ack(8'hA2);
    wait_idle();
    send_hdr(4'd1, 14'h0010, 14'd3);
    collect(4, 1'b0);
    for (int i = 0; i < 4; i++) check("t1_rd", rx_at(i), {24'h0, exp1[i]});
    check("t1_busy_after", o_busy, 0);

    // 2: read 8 bytes with ready toggling
    send_hdr(4'd2, 14'h0020, 14'd7);
    for (int i = 0; i < 8; i++) send_byte(8'h5A + 8'(i * 19));
    expect_ack(8'hA2);
    wait_idle();
    send_hdr(4'd1, 14'h0020, 14'd7);
    @(negedge clk);
    @(negedge clk);
    check("t2_first_latency", o_out_valid, 1);
    collect(8, 1'b1);
    check("t2_count", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_rd", rx_at(i), {24'h0, 8'h5A + 8'(i * 19)});
    check("t2_no_extra", o_out_valid, 0);
    check("t2_busy_after", o_busy, 0);

    // 3: write wrapping past the top of RAM
    send_hdr(4'd2, 14'h3FFE, 14'd3);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    expect_ack(8'hA2);
    wait_idle();
    dev_check(14'h3FFE, 8'hC1, "t3_dev_3ffe");
    dev_check(14'h3FFF, 8'hC2, "t3_dev_3fff");
    dev_check(14'h0000, 8'hC3, "t3_dev_0000");
    dev_check(14'h0001, 8'hC4, "t3_dev_0001");
    dev_check(14'h0010, 8'h11, "t3_dev_0010");

    // 4: registers and sticky error
    send_hdr(4'd4, 14'h0000, 14'h0001);
    expect_ack(8'hA4);
    wait_idle();
    check("t4_dev_en", o_dev_en, 1);
    regrd(2'd1, 8'h01, "t4_status");
    regrd(2'd0, 8'h01, "t4_ctrl");
    regrd(2'd3, 8'h00, "t4_reg3");
    send_hdr(4'd9, 14'h0000, 14'h0000);
    expect_ack(8'hEE);
    wait_idle();
    regrd(2'd1, 8'h03, "t4_status_err");
    send_hdr(4'd4, 14'h0001, 14'h0002);
    expect_ack(8'hA4);
    wait_idle();
    regrd(2'd1, 8'h01, "t4_status_clr");

    // 5: device reset pulse
    send_hdr(4'd0, 14'h0000, 14'h0000);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_dev_rst) cnt++;
    end
    check("t5_rst_cycles", cnt, 4);
    check("t5_ctrl_kept", o_dev_en, 1);
`ifdef CMD_MEM_BRIDGE_ACK_EN
    expect_ack(8'hA0);
`else
    check("t5_no_output", o_out_valid, 0);
`endif
    wait_idle();
    check("t5_busy_after", o_busy, 0);

    // 6: reset in the middle of a stalled read
    send_hdr(4'd1, 14'h0020, 14'd7);
    repeat (3) @(negedge clk);
    check("t6_valid_before", o_out_valid, 1);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("t6_valid_rst", o_out_valid, 0);
    check("t6_busy_rst", o_busy, 0);
    check("t6_dev_en_rst", o_dev_en, 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    regrd(2'd2, 8'h00, "t6_cmd_cnt0");
    regrd(2'd2, 8'h01, "t6_cmd_cnt1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
